// File: rtl/mips_hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard stall/flush unit.
package mips_hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  // Control bundle zeroed into ID/EX on a bubble or into IF/ID on a flush.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  function automatic logic load_use(
    input logic                 ex_mem_read,
    input logic [REG_IDX_W-1:0] ex_rt,
    input logic [REG_IDX_W-1:0] id_rs,
    input logic [REG_IDX_W-1:0] id_rt,
    input logic                 id_uses_rt
  );
    return ex_mem_read && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// Freeze-cycle counter: load on freeze entry, count while waiting, flag timeout.
module hazard_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  input  logic clear,
  output logic expired
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  // count_inc is the number of freeze cycles including the current one.
  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign expired   = count_inc >= (CNT_W+1)'(MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (inc && !(&count)) begin
      count <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, memory-wait freeze and branch flush control beside the ID stage.
// Optional HAZARD_STATS_EN adds saturating stall/freeze cycle counters.
module hazard_stall_unit
  import mips_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] IF_ID_Reg_Rs,
  input  logic [REG_IDX_W-1:0] IF_ID_Reg_Rt,
  input  logic                 IF_ID_UsesRt,
  input  logic                 ID_EX_MemRead,
  input  logic [REG_IDX_W-1:0] ID_EX_Reg_Rt,
  input  logic                 Branch_Taken_ID,
  input  logic                 Mem_Req_MEM,
  input  logic                 Mem_Ready,
`ifdef HAZARD_STATS_EN
  output logic [31:0]          Stall_Cycles,
  output logic [31:0]          Freeze_Cycles,
`endif
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Bubble,
  output logic                 Pipe_Freeze,
  output logic                 Mem_Timeout
);

  state_t state;
  logic   flush_pend;
  logic   lu;
  logic   mem_stall;
  logic   expired;

  assign lu        = load_use(ID_EX_MemRead, ID_EX_Reg_Rt, IF_ID_Reg_Rs,
                              IF_ID_Reg_Rt, IF_ID_UsesRt);
  assign mem_stall = Mem_Req_MEM && !Mem_Ready;

  hazard_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == RUN && mem_stall),
    .inc    (state == MEM_WAIT),
    .clear  (state == MEM_WAIT && Mem_Ready),
    .expired(expired)
  );

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Freeze  = 1'b0;
    if (!rst_n) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
          end else if (lu) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (Branch_Taken_ID) begin
            IF_ID_Flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          Pipe_Freeze = 1'b1;
          IF_ID_Flush = Mem_Ready && flush_pend;
        end
        default: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          Pipe_Freeze = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      flush_pend  <= 1'b0;
      Mem_Timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state      <= MEM_WAIT;
            flush_pend <= Branch_Taken_ID && !lu;
          end
        end
        MEM_WAIT: begin
          // A completing access beats a simultaneous timeout.
          if (Mem_Ready) begin
            state      <= RUN;
            flush_pend <= 1'b0;
          end else if (expired) begin
            state       <= ERROR;
            Mem_Timeout <= 1'b1;
          end
        end
        default: state <= ERROR;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Stall_Cycles  <= '0;
      Freeze_Cycles <= '0;
    end else begin
      if (ID_EX_Bubble && !(&Stall_Cycles))
        Stall_Cycles <= Stall_Cycles + 32'd1;
      if (Pipe_Freeze && !(&Freeze_Cycles))
        Freeze_Cycles <= Freeze_Cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed table plus multi-cycle sequences for hazard_stall_unit (MEM_TIMEOUT=4).
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, mem_read, br, req, rdy;
  logic       pc_write, ifid_write, ifid_flush, bubble, freeze, timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, freeze_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_Reg_Rs   (rs),
    .IF_ID_Reg_Rt   (rt),
    .IF_ID_UsesRt   (uses_rt),
    .ID_EX_MemRead  (mem_read),
    .ID_EX_Reg_Rt   (ex_rt),
    .Branch_Taken_ID(br),
    .Mem_Req_MEM    (req),
    .Mem_Ready      (rdy),
`ifdef HAZARD_STATS_EN
    .Stall_Cycles   (stall_cycles),
    .Freeze_Cycles  (freeze_cycles),
`endif
    .PC_Write       (pc_write),
    .IF_ID_Write    (ifid_write),
    .IF_ID_Flush    (ifid_flush),
    .ID_EX_Bubble   (bubble),
    .Pipe_Freeze    (freeze),
    .Mem_Timeout    (timeout)
  );

  // Expected output patterns {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Mem_Timeout}
  localparam logic [5:0] NORM   = 6'b110000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] FLUSH  = 6'b111000;
  localparam logic [5:0] FRZ    = 6'b000010;
  localparam logic [5:0] FRZ_FL = 6'b001010;
  localparam logic [5:0] RST    = 6'b001100;
  localparam logic [5:0] ERR    = 6'b000011;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ex_rt;
    logic       uses_rt, mem_read, br, req, rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic apply(input logic rn, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic a_uses, input logic a_mr, input logic [4:0] a_ert,
                       input logic a_br, input logic a_req, input logic a_rdy);
    @(negedge clk);
    rst_n = rn; rs = a_rs; rt = a_rt; uses_rt = a_uses; mem_read = a_mr;
    ex_rt = a_ert; br = a_br; req = a_req; rdy = a_rdy;
    #2;
  endtask

  task automatic idle(input logic rn);
    apply(rn, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string nm, input logic [5:0] exp);
    logic [5:0] got;
    got = {pc_write, ifid_write, ifid_flush, bubble, freeze, timeout};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", nm, got, exp);
    end else begin
      $display("ok   %s: outs=%b", nm, got);
    end
  endtask

  initial begin
    vecs[0] = '{"idle",             5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[1] = '{"lu_rs5",           5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[2] = '{"after_lu",         5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[3] = '{"lu_r0",            5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[4] = '{"lu_rt7_nouse",     5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5] = '{"lu_rt7_use",       5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[6] = '{"branch",           5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, FLUSH};
    vecs[7] = '{"branch_and_lu",    5'd6, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, STALL};
    vecs[8] = '{"zero_wait_mem",    5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NORM};
    vecs[9] = '{"load_no_match",    5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NORM};

    idle(1'b0);
    idle(1'b0);
    check("reset_forced", RST);

    foreach (vecs[i]) begin
      apply(1'b1, vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read,
            vecs[i].ex_rt, vecs[i].br, vecs[i].req, vecs[i].rdy);
      check(vecs[i].name, vecs[i].exp);
    end

    // Three wait cycles then ready: freeze over four cycles, then back to RUN.
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); check("frz_c1", FRZ);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); check("frz_c2", FRZ);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); check("frz_c3", FRZ);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); check("frz_release", FRZ);
    idle(1'b1); check("frz_back_run", NORM);

    // Branch taken on freeze entry: flush only in the release cycle.
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); check("brfrz_entry", FRZ);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); check("brfrz_wait", FRZ);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); check("brfrz_release", FRZ_FL);
    idle(1'b1); check("brfrz_after", NORM);

    // Branch with load-use on freeze entry: no pending flush recorded.
    apply(1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0); check("brlu_entry", FRZ);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); check("brlu_release", FRZ);
    idle(1'b1); check("brlu_after", NORM);

    // Reset in the middle of a memory wait returns to RUN.
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); check("rstwait_entry", FRZ);
    apply(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); check("rstwait_reset", RST);
    idle(1'b1); check("rstwait_run", NORM);

    // Timeout: four freeze cycles without ready, then sticky error until reset.
    for (int c = 1; c <= 4; c++) begin
      apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      check($sformatf("tmo_frz_c%0d", c), FRZ);
    end
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); check("tmo_set", ERR);
    apply(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); check("tmo_ready_ignored", ERR);
    idle(1'b1); check("tmo_sticky", ERR);
    idle(1'b0); check("tmo_in_reset", 6'b001101);
    idle(1'b1); check("tmo_cleared", NORM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
